// File: rtl/sd_sector_responder.sv
// Sector-request responder: moves one 512-byte sector between the drive-side
// buffer port and a byte-wide image memory for each sd_rd/sd_wr request.
module sd_sector_responder #(
   parameter int MEM_AW  = 24,
   parameter int DIN_LAT = 2
) (
   input  logic               sd_clk,
   input  logic               reset,
   input  logic [31:0]        sd_lba,
   input  logic               sd_rd,
   input  logic               sd_wr,
   output logic               sd_ack,
   output logic [8:0]         sd_buff_addr,
   output logic [7:0]         sd_buff_dout,
   input  logic [7:0]         sd_buff_din,
   output logic               sd_buff_wr,
   input  logic               img_mounted,
   input  logic [MEM_AW-10:0] img_size,
   input  logic               img_wp,
   output logic [MEM_AW-1:0]  mem_addr,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic [7:0]         mem_din,
   input  logic [7:0]         mem_dout,
   input  logic               mem_ready
);
   localparam int LBA_W = MEM_AW - 9;
   localparam int CNT_W = $clog2(DIN_LAT + 1);

   typedef enum logic [2:0] {
      IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_WAIT, WR_MEM, FINISH, RELEASE
   } state_t;

   state_t             state_q, state_d;
   logic [LBA_W-1:0]   lba_q, lba_d;
   logic               valid_q, valid_d;
   logic               wp_q, wp_d;
   logic               quiet_q, quiet_d;
   logic [8:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic               bwr_q, bwr_d;
   logic [8:0]         baddr_q, baddr_d;
   logic [7:0]         bdout_q, bdout_d;
   logic               mrd_q, mrd_d;
   logic               mwr_q, mwr_d;
   logic [MEM_AW-1:0]  maddr_q, maddr_d;
   logic [7:0]         mdin_q, mdin_d;
   logic               lba_ok;
   logic               last;

   // LBA bits beyond the image address space make the request out of range
   assign lba_ok = ((sd_lba >> LBA_W) == 32'd0) && (sd_lba[LBA_W-1:0] < img_size);
   assign last   = (idx_q == 9'd511);

   always_comb begin
      state_d = state_q;
      lba_d   = lba_q;
      valid_d = valid_q;
      wp_d    = wp_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      bwr_d   = 1'b0;
      baddr_d = baddr_q;
      bdout_d = bdout_q;
      mrd_d   = mrd_q;
      mwr_d   = mwr_q;
      maddr_d = maddr_q;
      mdin_d  = mdin_q;
      quiet_d = quiet_q | (~sd_rd & ~sd_wr);
      case (state_q)
         IDLE: begin
            if (sd_rd | sd_wr) begin
               lba_d   = sd_lba[LBA_W-1:0];
               valid_d = img_mounted & lba_ok;
               wp_d    = img_wp;
               idx_d   = '0;
               ack_d   = 1'b1;
               quiet_d = 1'b0;
               state_d = sd_rd ? RD_MEM : WR_ADDR;
            end
         end
         RD_MEM: begin
            if (!valid_q) begin
               bwr_d   = 1'b1;
               baddr_d = idx_q;
               bdout_d = 8'h00;
               state_d = RD_PUT;
            end else if (!mrd_q) begin
               mrd_d   = 1'b1;
               maddr_d = {lba_q, idx_q};
            end else if (mem_ready) begin
               mrd_d   = 1'b0;
               bwr_d   = 1'b1;
               baddr_d = idx_q;
               bdout_d = mem_dout;
               state_d = RD_PUT;
            end
         end
         RD_PUT: begin
            if (last) begin
               state_d = FINISH;
            end else begin
               idx_d   = idx_q + 9'd1;
               state_d = RD_MEM;
            end
         end
         WR_ADDR: begin
            baddr_d = idx_q;
            cnt_d   = '0;
            state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (cnt_q == CNT_W'(DIN_LAT - 1)) begin
               mdin_d  = sd_buff_din;
               state_d = WR_MEM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_MEM: begin
            // protected or out-of-range writes still walk all 512 bytes
            if (valid_q && !wp_q && !mwr_q) begin
               mwr_d   = 1'b1;
               maddr_d = {lba_q, idx_q};
            end else if (!valid_q || wp_q || mem_ready) begin
               mwr_d = 1'b0;
               if (last) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + 9'd1;
                  state_d = WR_ADDR;
               end
            end
         end
         FINISH: begin
            if (quiet_q | (~sd_rd & ~sd_wr)) begin
               ack_d   = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sd_clk) begin
      if (reset) begin
         state_q <= IDLE;
         lba_q   <= '0;
         valid_q <= 1'b0;
         wp_q    <= 1'b0;
         quiet_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         bwr_q   <= 1'b0;
         baddr_q <= '0;
         bdout_q <= '0;
         mrd_q   <= 1'b0;
         mwr_q   <= 1'b0;
         maddr_q <= '0;
         mdin_q  <= '0;
      end else begin
         state_q <= state_d;
         lba_q   <= lba_d;
         valid_q <= valid_d;
         wp_q    <= wp_d;
         quiet_q <= quiet_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         bwr_q   <= bwr_d;
         baddr_q <= baddr_d;
         bdout_q <= bdout_d;
         mrd_q   <= mrd_d;
         mwr_q   <= mwr_d;
         maddr_q <= maddr_d;
         mdin_q  <= mdin_d;
      end
   end

   assign sd_ack       = ack_q;
   assign sd_buff_wr   = bwr_q;
   assign sd_buff_addr = baddr_q;
   assign sd_buff_dout = bdout_q;
   assign mem_rd       = mrd_q;
   assign mem_wr       = mwr_q;
   assign mem_addr     = maddr_q;
   assign mem_din      = mdin_q;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: random-latency image memory, delayed drive
// buffer read port, and a per-sector reference of what must move where.
module tb_sd_sector_responder;
   localparam int MEM_AW = 24;

   logic        sd_clk, reset;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout, sd_buff_din;
   logic        sd_buff_wr;
   logic        img_mounted, img_wp;
   logic [14:0] img_size;
   logic [23:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_din, mem_dout;
   logic        mem_ready;

   sd_sector_responder #(.MEM_AW(MEM_AW), .DIN_LAT(2)) dut (
      .sd_clk(sd_clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_mounted(img_mounted),
      .img_size(img_size), .img_wp(img_wp), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready)
   );

   initial sd_clk = 1'b0;
   always #5 sd_clk = ~sd_clk;

   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // observed traffic for the current sector
   int strobes, ord_err, both_err, stab_err, rdops, wrops, waddr_err;
   int rd_buf[512], wr_buf[512], wr_hit[512];
   logic [14:0] cur_lba;
   int mcnt = 0, mlat = 1;
   logic        prev_req = 1'b0;
   logic [23:0] prev_addr = '0;
   logic [7:0]  din_nxt = '0;

   task automatic clr();
      strobes = 0; ord_err = 0; both_err = 0; stab_err = 0;
      rdops = 0; wrops = 0; waddr_err = 0;
      for (int i = 0; i < 512; i++) begin
         rd_buf[i] = -1; wr_buf[i] = -1; wr_hit[i] = 0;
      end
   endtask

   // monitors plus memory and buffer responders, all away from the active edge
   always @(negedge sd_clk) begin
      if (sd_buff_wr) begin
         if (int'(sd_buff_addr) != strobes) ord_err++;
         rd_buf[sd_buff_addr] = int'(sd_buff_dout);
         strobes++;
      end
      if (mem_rd && mem_wr) both_err++;
      if ((mem_rd || mem_wr) && prev_req && mem_addr != prev_addr) stab_err++;
      prev_req  = mem_rd || mem_wr;
      prev_addr = mem_addr;

      sd_buff_din = din_nxt;
      din_nxt     = ~sd_buff_addr[7:0];

      if (reset) begin
         mem_ready = 1'b0; mcnt = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_rd || mem_wr) begin
         if (mcnt == 0) mlat = $urandom_range(1, 4);
         mcnt++;
         if (mcnt >= mlat) begin
            mcnt = 0;
            mem_ready = 1'b1;
            if (mem_rd) begin
               rdops++;
               mem_dout = mem_addr[7:0] ^ mem_addr[16:9];
            end else begin
               wrops++;
               if (mem_addr[23:9] != cur_lba) waddr_err++;
               wr_buf[mem_addr[8:0]] = int'(mem_din);
               wr_hit[mem_addr[8:0]]++;
            end
         end
      end
   end

   task automatic xfer(input bit rd, input bit both, input logic [31:0] lba, input bit hold,
                       input bit mnt, input logic [14:0] size, input bit wp);
      bit is_rd, valid;
      int n, errs, e;
      is_rd = rd | both;
      valid = mnt && (lba < {17'd0, size});
      clr();
      cur_lba     = lba[14:0];
      img_mounted = mnt; img_size = size; img_wp = wp;
      sd_lba = lba; sd_rd = rd | both; sd_wr = !rd | both;
      n = 0;
      while (!sd_ack && n < 8) begin @(negedge sd_clk); n++; end
      chk("ack_rise", sd_ack, 1);
      // everything below must have been captured at acceptance
      sd_lba = $urandom; img_size = 15'($urandom); img_wp = 1'($urandom); img_mounted = 1'($urandom);
      if (hold) begin
         n = 0;
         while (strobes < 512 && n < 8000) begin @(negedge sd_clk); n++; end
         repeat (4) @(negedge sd_clk);
         chk("ack_hold", sd_ack, 1);
         sd_rd = 1'b0; sd_wr = 1'b0;
         @(negedge sd_clk);
         chk("ack_drop", sd_ack, 0);
      end else begin
         sd_rd = 1'b0; sd_wr = 1'b0;
         n = 0;
         while (sd_ack && n < 8000) begin @(negedge sd_clk); n++; end
         chk("ack_fall", sd_ack, 0);
      end
      chk("strobes", strobes, is_rd ? 512 : 0);
      chk("order", ord_err, 0);
      chk("rw_excl", both_err, 0);
      chk("addr_stab", stab_err, 0);
      if (is_rd) begin
         errs = 0;
         for (int i = 0; i < 512; i++) begin
            e = valid ? ((i ^ int'(lba)) & 255) : 0;
            if (rd_buf[i] != e) errs++;
         end
         chk("rd_data", errs, 0);
         chk("rd_ops", rdops, valid ? 512 : 0);
         chk("wr_ops", wrops, 0);
      end else begin
         chk("wr_ops", wrops, (valid && !wp) ? 512 : 0);
         chk("rd_ops", rdops, 0);
         if (valid && !wp) begin
            errs = 0;
            for (int i = 0; i < 512; i++)
               if (wr_hit[i] != 1 || wr_buf[i] != ((~i) & 255)) errs++;
            chk("wr_data", errs, 0);
            chk("wr_addr", waddr_err, 0);
         end
      end
   endtask

   initial begin
      int n;
      reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
      img_mounted = 1'b0; img_size = '0; img_wp = 1'b0;
      mem_dout = '0; mem_ready = 1'b0; sd_buff_din = '0;
      clr();
      repeat (3) @(negedge sd_clk);
      chk("rst_ack", sd_ack, 0);
      chk("rst_bwr", sd_buff_wr, 0);
      chk("rst_baddr", sd_buff_addr, 0);
      chk("rst_bdout", sd_buff_dout, 0);
      chk("rst_mrd", mem_rd, 0);
      chk("rst_mwr", mem_wr, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mdin", mem_din, 0);
      reset = 1'b0;
      @(negedge sd_clk);

      xfer(1, 0, 32'd5, 0, 1, 15'd100, 0);      // plain read
      xfer(0, 0, 32'd2, 0, 1, 15'd100, 0);      // plain write
      xfer(0, 0, 32'd3, 0, 1, 15'd100, 1);      // write protected
      xfer(0, 0, 32'd100, 0, 1, 15'd100, 0);    // write past end of image
      xfer(1, 0, 32'd100, 0, 1, 15'd100, 0);    // read past end of image
      xfer(1, 0, 32'h8003, 0, 1, 15'd100, 0);   // high LBA bits set
      xfer(1, 0, 32'd7, 1, 1, 15'd100, 0);      // requester holds sd_rd
      xfer(1, 0, 32'd8, 0, 1, 15'd100, 0);      // immediate next sector
      xfer(1, 1, 32'd11, 0, 1, 15'd100, 0);     // rd and wr together
      xfer(0, 0, 32'd4, 0, 0, 15'd100, 0);      // no image mounted
      for (int k = 0; k < 4; k++)
         xfer(1'($urandom), 1'b0, 32'($urandom_range(0, 40)), 1'b0,
              ($urandom % 8) != 0, 15'($urandom_range(1, 40)), ($urandom % 4) == 0);

      // reset in the middle of a read
      clr();
      cur_lba = 15'd9;
      img_mounted = 1'b1; img_size = 15'd50; img_wp = 1'b0;
      sd_lba = 32'd9; sd_rd = 1'b1;
      n = 0;
      while (!sd_ack && n < 8) begin @(negedge sd_clk); n++; end
      sd_rd = 1'b0;
      n = 0;
      while (strobes < 201 && n < 3000) begin @(negedge sd_clk); n++; end
      chk("rst_at", strobes, 201);
      reset = 1'b1;
      @(negedge sd_clk);
      chk("mid_rst_ack", sd_ack, 0);
      chk("mid_rst_mrd", mem_rd, 0);
      reset = 1'b0;
      repeat (20) @(negedge sd_clk);
      chk("mid_rst_quiet", strobes, 201);
      chk("mid_rst_ack2", sd_ack, 0);
      xfer(1, 0, 32'd10, 0, 1, 15'd50, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
